// File: rtl/seg7_disp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg7_disp_pkg                                              |
// | Description : Shared definitions for the 7-segment display sequencer:    |
// |               operator code constants, sequencer state type, the         |
// |               request record and a small helper for counter sizing.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seg7_disp_pkg;

   // Operator symbol codes understood by the 7-segment driver.
   // Any other value is shown as the error symbol.
   localparam logic [2:0] OP_T = 3'd0;
   localparam logic [2:0] OP_A = 3'd1;
   localparam logic [2:0] OP_C = 3'd2;
   localparam logic [2:0] OP_B = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHOW_OP  = 3'd1,
      ST_GAP      = 3'd2,
      ST_SHOW_VAL = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   // One display request as captured at the handshake.
   typedef struct packed {
      logic [2:0] op;
      logic [3:0] val;
      logic       blink;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_req_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg7_req_slot                                              |
// | Description : One-entry holding register for a queued display request.  |
// |               Ports: clk, rst (sync, active-high), clear_i (drop entry), |
// |               load_i (store data_i, set full), pop_i (release entry),    |
// |               data_i / data_o (request bits), full_o (entry valid).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg7_req_slot
   import seg7_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             pop_i,
   input  logic [REQ_W-1:0] data_i,
   output logic [REQ_W-1:0] data_o,
   output logic             full_o
);

   logic [REQ_W-1:0] data_q;
   logic             full_q;

   // Clear wins over load so that an abort can never leave a stale entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else if (pop_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/seg7_disp_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg7_disp_sequencer                                        |
// | Description : Timed sequencer feeding the 7-segment driver. Each request |
// |               plays operator symbol, blank gap, result digit (optional   |
// |               blink) and a one-cycle done pulse. One further request can |
// |               be queued while the current one is on screen.              |
// |   Ports     : clk, rst (sync, active-high)                               |
// |               i_valid/o_ready  request handshake                         |
// |               i_op_code, i_val, i_blink  request fields                  |
// |               i_abort          drop current and queued requests          |
// |               o_en, o_disp_mode, o_op_code, o_digit_val  driver control  |
// |               o_done (end-of-sequence pulse), o_busy (not idle)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg7_disp_sequencer
   import seg7_disp_pkg::*;
#(
   parameter int OP_CYC    = 50_000_000,
   parameter int GAP_CYC   = 10_000_000,
   parameter int VAL_CYC   = 100_000_000,
   parameter int BLINK_CYC = 12_500_000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [2:0] i_op_code,
   input  logic [3:0] i_val,
   input  logic       i_blink,
   input  logic       i_abort,
   output logic       o_en,
   output logic       o_disp_mode,
   output logic [2:0] o_op_code,
   output logic [3:0] o_digit_val,
   output logic       o_done,
   output logic       o_busy
);

   localparam int MAX_CYC = max3(OP_CYC, GAP_CYC, VAL_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int BLK_W   = $clog2(BLINK_CYC + 1);

   // Counters load N-1 on entry and the state moves on when they reach zero,
   // so a phase lasts exactly N cycles and the counter never wraps.
   localparam logic [CNT_W-1:0] OP_LOAD  = CNT_W'(OP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] VAL_LOAD = CNT_W'(VAL_CYC - 1);
   localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLINK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] dwell_q,   dwell_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             blk_on_q,  blk_on_d;
   req_t             work_q,    work_d;

   logic             en_q,   en_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             accept;
   req_t             req_in;
   logic             slot_load;
   logic             slot_pop;
   logic             slot_clear;
   logic             pend_full;
   req_t             pend_data;
   logic             go_op;
   logic             go_gap;
   logic             go_val;

   assign o_ready = !pend_full && !i_abort && !rst;
   assign accept  = i_valid && o_ready;
   assign req_in  = '{op: i_op_code, val: i_val, blink: i_blink};

   seg7_req_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .clear_i (slot_clear),
      .load_i  (slot_load),
      .pop_i   (slot_pop),
      .data_i  (req_in),
      .data_o  (pend_data),
      .full_o  (pend_full)
   );

   always_comb begin
      state_d    = state_q;
      dwell_d    = dwell_q;
      blk_cnt_d  = blk_cnt_q;
      blk_on_d   = blk_on_q;
      work_d     = work_q;
      slot_load  = 1'b0;
      slot_pop   = 1'b0;
      slot_clear = 1'b0;
      go_op      = 1'b0;
      go_gap     = 1'b0;
      go_val     = 1'b0;

      if (i_abort) begin
         state_d    = ST_IDLE;
         slot_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  work_d = req_in;
                  go_op  = 1'b1;
               end
            end

            ST_SHOW_OP: begin
               slot_load = accept;
               if (dwell_q == '0) begin
                  if (GAP_CYC == 0) begin
                     go_val = 1'b1;
                  end else begin
                     go_gap = 1'b1;
                  end
               end else begin
                  dwell_d = dwell_q - CNT_ONE;
               end
            end

            ST_GAP: begin
               slot_load = accept;
               if (dwell_q == '0) begin
                  go_val = 1'b1;
               end else begin
                  dwell_d = dwell_q - CNT_ONE;
               end
            end

            ST_SHOW_VAL: begin
               slot_load = accept;
               if (blk_cnt_q == '0) begin
                  blk_cnt_d = BLK_LOAD;
                  blk_on_d  = !blk_on_q;
               end else begin
                  blk_cnt_d = blk_cnt_q - BLK_ONE;
               end
               if (dwell_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  dwell_d = dwell_q - CNT_ONE;
               end
            end

            ST_DONE: begin
               // A queued request always has precedence; while it is held
               // o_ready is low, so a new accept cannot collide with the pop.
               if (pend_full) begin
                  work_d   = pend_data;
                  slot_pop = 1'b1;
                  go_op    = 1'b1;
               end else if (accept) begin
                  work_d = req_in;
                  go_op  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (go_op) begin
            state_d = ST_SHOW_OP;
            dwell_d = OP_LOAD;
         end
         if (go_gap) begin
            state_d = ST_GAP;
            dwell_d = GAP_LOAD;
         end
         if (go_val) begin
            // Blink phase restarts with the digit visible.
            state_d   = ST_SHOW_VAL;
            dwell_d   = VAL_LOAD;
            blk_cnt_d = BLK_LOAD;
            blk_on_d  = 1'b1;
         end
      end

      // Outputs are decoded from the next state so they register in step
      // with the state they describe.
      en_d   = (state_d == ST_SHOW_OP) ||
               ((state_d == ST_SHOW_VAL) && (!work_d.blink || blk_on_d));
      mode_d = (state_d == ST_SHOW_VAL);
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dwell_q   <= '0;
         blk_cnt_q <= '0;
         blk_on_q  <= 1'b0;
         work_q    <= '0;
         en_q      <= 1'b0;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         blk_cnt_q <= blk_cnt_d;
         blk_on_q  <= blk_on_d;
         work_q    <= work_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign o_en        = en_q;
   assign o_disp_mode = mode_q;
   assign o_op_code   = work_q.op;
   assign o_digit_val = work_q.val;
   assign o_done      = done_q;
   assign o_busy      = busy_q;

endmodule
`default_nettype wire
